diff_deframer: RTL

Receive-side counterpart of the differential line encoder, which drives line[n+1] = line[n] ^ bit[n] from a line register that resets to 0. This block undoes the differential coding on a 1-bit line and hunts for an 8-bit sync word. After sync it deserialises a fixed-length frame of payload bytes, MSB first, and presents each byte with a one-cycle valid strobe. It sits between the serial line input and the byte-wide packet logic.

---
 rtl/diff_deframer_if.sv | 21 ++
 rtl/diff_deframer.sv | 90 +++++++++
 2 files changed

// File: rtl/diff_deframer_if.sv
// Serial line in / byte stream out bundle for diff_deframer.
// master drives the line side, slave is the deframer.
interface diff_deframer_if;
    logic       line_in;
    logic       line_en;
    logic [7:0] data_out;
    logic       data_valid;
    logic       frame_start;
    logic       frame_end;
    logic       locked;

    modport master (
        output line_in, line_en,
        input  data_out, data_valid, frame_start, frame_end, locked
    );

    modport slave (
        input  line_in, line_en,
        output data_out, data_valid, frame_start, frame_end, locked
    );
endinterface

// File: rtl/diff_deframer.sv
// Differential line decoder with bit-sliding sync hunt and fixed-length
// MSB-first payload deserialiser; all outputs registered.
module diff_deframer #(
    parameter logic [7:0]  SYNC_WORD = 8'hA5,
    parameter int unsigned FRAME_LEN = 4
) (
    input logic           clk,
    input logic           rst,
    diff_deframer_if.slave bus
);
    localparam logic [7:0] LAST_IDX = 8'(FRAME_LEN - 1);

    typedef enum logic {HUNT, PAYLOAD} state_t;

    state_t     r_state;
    state_t     w_state_nxt;
    logic       r_prev;
    logic [7:0] r_sr;
    logic [2:0] r_bit_cnt;
    logic [7:0] r_byte_cnt;
    logic [7:0] r_data_out;
    logic       r_valid;
    logic       r_start;
    logic       r_end;

    logic       w_d;
    logic [7:0] w_w;
    logic       w_sync_hit;
    logic       w_byte_done;
    logic       w_last;

    assign w_d = bus.line_in ^ r_prev;
    assign w_w = {r_sr[6:0], w_d};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= HUNT;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            HUNT:    if (w_sync_hit) w_state_nxt = PAYLOAD;
            PAYLOAD: if (w_last)     w_state_nxt = HUNT;
            default: w_state_nxt = HUNT;
        endcase
    end

    always_comb begin
        w_sync_hit  = bus.line_en && (r_state == HUNT) && (w_w == SYNC_WORD);
        w_byte_done = bus.line_en && (r_state == PAYLOAD) && (r_bit_cnt == 3'd7);
        w_last      = w_byte_done && (r_byte_cnt == LAST_IDX);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_prev     <= 1'b0;
            r_sr       <= '0;
            r_bit_cnt  <= '0;
            r_byte_cnt <= '0;
            r_data_out <= '0;
            r_valid    <= 1'b0;
            r_start    <= 1'b0;
            r_end      <= 1'b0;
        end else begin
            r_valid <= w_byte_done;
            r_start <= w_sync_hit;
            r_end   <= w_last;
            if (w_byte_done) r_data_out <= w_w;
            if (bus.line_en) begin
                r_prev <= bus.line_in;
                // Clearing sr on lock and on frame end keeps payload bits out of the next hunt
                r_sr   <= (w_sync_hit || w_last) ? '0 : w_w;
                if (w_sync_hit) begin
                    r_bit_cnt  <= '0;
                    r_byte_cnt <= '0;
                end else if (r_state == PAYLOAD) begin
                    r_bit_cnt <= r_bit_cnt + 3'd1;
                    if (w_byte_done) r_byte_cnt <= r_byte_cnt + 8'd1;
                end
            end
        end
    end

    assign bus.data_out    = r_data_out;
    assign bus.data_valid  = r_valid;
    assign bus.frame_start = r_start;
    assign bus.frame_end   = r_end;
    assign bus.locked      = (r_state == PAYLOAD);
endmodule
